wb_master_arbiter: RTL and testbench

- Shares one wb_master_interface command port between two bus requesters.
- Requester 0 is the UART packet decoder; requester 1 is a second on-chip master, e.g. a self-test or DMA sequencer.
- Grants transfers round-robin, sequences the start/active handshake of the downstream master, and aborts transfers that hang.
- Sits between packet_decode (and peer) and wb_master_interface inside the PC-interface path.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_master_arbiter_rr.sv | 24 ++
 rtl/wb_master_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone master arbiter.
package wb_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACT,
    BUSY,
    FINISH
  } arb_state_t;

  typedef logic req_id_t;

endpackage : wb_arb_pkg

// File: rtl/wb_master_arbiter_rr.sv
// Combinational round-robin pick between two requesters; the last_grant
// history register lives in the parent.
module rr_arbiter_2
  import wb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last_grant,
  output logic               gnt_valid,
  output req_id_t            gnt_id
);

  // On a tie the requester that did not win last time goes next
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    unique case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule : rr_arbiter_2

// File: rtl/wb_master_arbiter.sv
// Shares one wb_master_interface command port between two requesters:
// round-robin grant, start/active handshake sequencing and hang watchdog.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [AW-1:0]      req0_address,
  input  logic [AW-1:0]      req1_address,
  input  logic [3:0]         req0_selection,
  input  logic [3:0]         req1_selection,
  input  logic               req0_write,
  input  logic               req1_write,
  input  logic [DW-1:0]      req0_data_wr,
  input  logic [DW-1:0]      req1_data_wr,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] error,
  output logic [DW-1:0]      data_rd,
  output logic               m_start,
  output logic [AW-1:0]      m_address,
  output logic [3:0]         m_selection,
  output logic               m_write,
  output logic [DW-1:0]      m_data_wr,
  input  logic [DW-1:0]      m_data_rd,
  input  logic               m_active,
  output logic               busy,
  output logic               grant_id
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  req_id_t             r_last_grant;
  req_id_t             r_grant_id;
  logic [TW-1:0]       r_wdog;
  logic [TW-1:0]       w_wdog_nxt;
  logic [TW-1:0]       w_wdog_inc;
  logic                w_gnt_valid;
  req_id_t             w_gnt_id;
  logic                w_grant_ld;
  logic                w_finish;
  logic                w_err;
  logic                w_start_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic [NUM_REQ-1:0]  w_error_nxt;

  logic                r_start;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_error;
  logic                r_busy;
  logic [DW-1:0]       r_data_rd;
  logic [AW-1:0]       r_address;
  logic [3:0]          r_selection;
  logic                r_write;
  logic [DW-1:0]       r_data_wr;

  rr_arbiter_2 u_rr (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  // Saturating watchdog increment so a long hang never wraps
  assign w_wdog_inc = (r_wdog == TW'(TIMEOUT)) ? r_wdog : r_wdog + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_grant_ld  = 1'b0;
    w_start_nxt = 1'b0;
    w_finish    = 1'b0;
    w_err       = 1'b0;
    w_done_nxt  = '0;
    w_error_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant_ld  = 1'b1;
          w_start_nxt = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = WAIT_ACT;
      end
      // A master that never raises m_active within two cycles is taken as done
      WAIT_ACT: begin
        w_wdog_nxt = w_wdog_inc;
        if (m_active) begin
          if (w_wdog_inc >= TW'(TIMEOUT)) begin
            w_finish = 1'b1;
            w_err    = 1'b1;
          end else begin
            w_state_nxt = BUSY;
          end
        end else if (r_wdog == TW'(1)) begin
          w_finish = 1'b1;
        end
      end
      BUSY: begin
        w_wdog_nxt = w_wdog_inc;
        if (!m_active) begin
          w_finish = 1'b1;
        end else if (w_wdog_inc >= TW'(TIMEOUT)) begin
          w_finish = 1'b1;
          w_err    = 1'b1;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_finish) begin
      w_state_nxt = FINISH;
      w_done_nxt  = r_grant_id ? 2'b10 : 2'b01;
      w_error_nxt = w_err ? w_done_nxt : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_wdog       <= '0;
      r_start      <= 1'b0;
      r_done       <= '0;
      r_error      <= '0;
      r_busy       <= 1'b0;
      r_data_rd    <= '0;
      r_address    <= '0;
      r_selection  <= '0;
      r_write      <= 1'b0;
      r_data_wr    <= '0;
    end else begin
      r_wdog  <= w_wdog_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_grant_ld) begin
        r_grant_id   <= w_gnt_id;
        r_last_grant <= w_gnt_id;
        r_address    <= w_gnt_id ? req1_address   : req0_address;
        r_selection  <= w_gnt_id ? req1_selection : req0_selection;
        r_write      <= w_gnt_id ? req1_write     : req0_write;
        r_data_wr    <= w_gnt_id ? req1_data_wr   : req0_data_wr;
      end
      // Aborted transfers leave the previous read data in place
      if (w_finish && !w_err && !r_write) begin
        r_data_rd <= m_data_rd;
      end
    end
  end

  assign done        = r_done;
  assign error       = r_error;
  assign data_rd     = r_data_rd;
  assign m_start     = r_start;
  assign m_address   = r_address;
  assign m_selection = r_selection;
  assign m_write     = r_write;
  assign m_data_wr   = r_data_wr;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;

endmodule : wb_master_arbiter

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order and completion time.
module tb_wb_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [AW-1:0] req0_address, req1_address;
  logic [3:0]    req0_selection, req1_selection;
  logic          req0_write, req1_write;
  logic [DW-1:0] req0_data_wr, req1_data_wr;
  logic [1:0]    done, error;
  logic [DW-1:0] data_rd;
  logic          m_start;
  logic [AW-1:0] m_address;
  logic [3:0]    m_selection;
  logic          m_write;
  logic [DW-1:0] m_data_wr, m_data_rd;
  logic          m_active, busy, grant_id;

  int checks = 0;
  int errors = 0;
  int mdl_last;
  logic [DW-1:0] mdl_rd;
  logic [AW-1:0] pl_addr [2];
  logic [3:0]    pl_sel  [2];
  logic          pl_wr   [2];
  logic [DW-1:0] pl_dat  [2];

  wb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req0_address(req0_address), .req1_address(req1_address),
    .req0_selection(req0_selection), .req1_selection(req1_selection),
    .req0_write(req0_write), .req1_write(req1_write),
    .req0_data_wr(req0_data_wr), .req1_data_wr(req1_data_wr),
    .done(done), .error(error), .data_rd(data_rd),
    .m_start(m_start), .m_address(m_address), .m_selection(m_selection),
    .m_write(m_write), .m_data_wr(m_data_wr), .m_data_rd(m_data_rd),
    .m_active(m_active), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [3:0] s,
                         input logic w, input logic [DW-1:0] d);
    pl_addr[id] = a; pl_sel[id] = s; pl_wr[id] = w; pl_dat[id] = d;
    if (id == 0) begin
      req0_address = a; req0_selection = s; req0_write = w; req0_data_wr = d;
    end else begin
      req1_address = a; req1_selection = s; req1_write = w; req1_data_wr = d;
    end
  endtask

  // Round-robin rule: lone requester wins, a tie goes to the one not served last
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - mdl_last;
    return r[1] ? 1 : 0;
  endfunction

  // Slave drives m_active in cycles [s, s+len) counted from the m_start cycle.
  // Returns the cycle in which done is expected and whether it is an abort.
  function automatic void xfer_model(input int s, input int len, output int k, output bit err);
    if (len == 0 || s > 2) begin
      k = 3; err = 1'b0;
    end else if (s + len > TO) begin
      k = TO + 1; err = 1'b1;
    end else begin
      k = s + len + 1; err = 1'b0;
    end
  endfunction

  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Called at the negedge of the m_start cycle; returns at the negedge showing done
  task automatic run_slave(input int s, input int len, input logic [DW-1:0] rd,
                           output int k, output logic [1:0] d, output logic [1:0] e);
    k = -1; d = 2'b00; e = 2'b00;
    for (int i = 0; i < 64; i++) begin
      if (i > 0 && done !== 2'b00) begin
        k = i; d = done; e = error;
        break;
      end
      m_active  = (i >= s) && (i < s + len);
      m_data_rd = rd;
      @(negedge clk);
    end
    m_active = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error, m_start, m_write, busy, grant_id} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {done, error, m_start, m_write, busy, grant_id});
    end
    checks++;
    if (data_rd !== '0) begin
      errors++; $display("FAIL reset_data_rd: got %h expected 0", data_rd);
    end
    checks++;
    if ({m_address, m_selection, m_data_wr} !== '0) begin
      errors++; $display("FAIL reset_cmd: got %h %h %h expected 0", m_address, m_selection, m_data_wr);
    end
    rst_n = 1'b1;
    mdl_last = 1; mdl_rd = '0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat, k; logic [1:0] d, e;
    set_req(0, 32'h0000_1000, 4'hF, 1'b0, '0);
    req_valid = 2'b01;
    wait_start(lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
    checks++;
    if (m_address !== 32'h0000_1000 || m_write !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cmd: got addr %h wr %b gid %b busy %b expected 00001000 0 0 1", m_address, m_write, grant_id, busy);
    end
    run_slave(1, 4, 32'hDEAD_BEEF, k, d, e);
    req_valid = 2'b00;
    mdl_last = 0; mdl_rd = 32'hDEAD_BEEF;
    checks++;
    if (k != 6 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL single_done: got cyc %0d done %b err %b expected 6 01 00", k, d, e);
    end
    checks++;
    if (data_rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_data_rd: got %h expected deadbeef", data_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    int lat, k; logic [1:0] d, e;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    mdl_last = 1; mdl_rd = '0;
    set_req(0, 32'h10, 4'hF, 1'b1, 32'h1111_1111);
    set_req(1, 32'h20, 4'hF, 1'b1, 32'h2222_2222);
    req_valid = 2'b11;
    wait_start(lat);
    checks++;
    if (grant_id !== 1'b0 || m_address !== 32'h10 || m_data_wr !== 32'h1111_1111 || m_write !== 1'b1) begin
      errors++;
      $display("FAIL tie_first: got gid %b addr %h data %h expected 0 00000010 11111111", grant_id, m_address, m_data_wr);
    end
    run_slave(1, 2, 32'h0, k, d, e);
    req_valid = 2'b10;
    checks++;
    if (d !== 2'b01) begin errors++; $display("FAIL tie_done0: got %b expected 01", d); end
    @(negedge clk);
    wait_start(lat);
    checks++;
    if (lat != 1 || grant_id !== 1'b1 || m_address !== 32'h20 || m_data_wr !== 32'h2222_2222) begin
      errors++;
      $display("FAIL tie_second: got lat %0d gid %b addr %h data %h expected 1 1 00000020 22222222", lat, grant_id, m_address, m_data_wr);
    end
    run_slave(1, 2, 32'h0, k, d, e);
    req_valid = 2'b00;
    mdl_last = 1;
    checks++;
    if (d !== 2'b10 || data_rd !== mdl_rd) begin
      errors++; $display("FAIL tie_done1: got done %b data_rd %h expected 10 %h", d, data_rd, mdl_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int lat, k; logic [1:0] d, e;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_start(lat);
      checks++;
      if (lat != 1 || grant_id !== 1'(i % 2)) begin
        errors++; $display("FAIL fair_grant%0d: got lat %0d gid %b expected 1 %0d", i, lat, grant_id, i % 2);
      end
      run_slave(1, 1, 32'h0, k, d, e);
      checks++;
      if (d !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL fair_done%0d: got %b expected one-hot for %0d", i, d, i % 2);
      end
      req_valid[i % 2] = 1'b0;
      @(negedge clk);
      if (i < 5) req_valid = 2'b11;
    end
    req_valid = 2'b00;
    mdl_last = 1;
  endtask

  task automatic test_timeout();
    int lat, k; logic [1:0] d, e;
    set_req(1, 32'h0000_0BAD, 4'h3, 1'b0, '0);
    req_valid = 2'b10;
    wait_start(lat);
    run_slave(1, 1000, 32'h1234_5678, k, d, e);
    req_valid = 2'b00;
    mdl_last = 1;
    checks++;
    if (k != TO + 1 || d !== 2'b10 || e !== 2'b10) begin
      errors++; $display("FAIL timeout_done: got cyc %0d done %b err %b expected %0d 10 10", k, d, e, TO + 1);
    end
    checks++;
    if (data_rd !== mdl_rd) begin
      errors++; $display("FAIL timeout_data_rd: got %h expected %h", data_rd, mdl_rd);
    end
    @(negedge clk);
    set_req(0, 32'h0000_0044, 4'h1, 1'b1, 32'hA5A5_A5A5);
    req_valid = 2'b01;
    wait_start(lat);
    run_slave(1, 2, 32'h0, k, d, e);
    req_valid = 2'b00;
    mdl_last = 0;
    checks++;
    if (lat != 1 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL timeout_next: got lat %0d done %b err %b expected 1 01 00", lat, d, e);
    end
    @(negedge clk);
  endtask

  task automatic test_no_active();
    int lat, k; logic [1:0] d, e;
    set_req(1, 32'h0000_0300, 4'hF, 1'b0, '0);
    req_valid = 2'b10;
    wait_start(lat);
    run_slave(1, 0, 32'hCAFE_F00D, k, d, e);
    req_valid = 2'b00;
    mdl_last = 1; mdl_rd = 32'hCAFE_F00D;
    checks++;
    if (k != 3 || d !== 2'b10 || e !== 2'b00) begin
      errors++; $display("FAIL noact_done: got cyc %0d done %b err %b expected 3 10 00", k, d, e);
    end
    checks++;
    if (data_rd !== mdl_rd) begin
      errors++; $display("FAIL noact_data_rd: got %h expected %h", data_rd, mdl_rd);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 2'b00) begin
      errors++; $display("FAIL noact_idle: got busy %b done %b expected 0 00", busy, done);
    end
  endtask

  task automatic test_deassert();
    int lat, k; logic [1:0] d, e;
    set_req(0, 32'h0000_0600, 4'hC, 1'b1, 32'h0BAD_CAFE);
    req_valid = 2'b01;
    wait_start(lat);
    req_valid = 2'b00;
    run_slave(1, 3, 32'h0, k, d, e);
    mdl_last = 0;
    checks++;
    if (k != 5 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL deassert_done: got cyc %0d done %b err %b expected 5 01 00", k, d, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, k; logic [1:0] d, e;
    set_req(0, 32'h0000_0500, 4'hF, 1'b0, '0);
    req_valid = 2'b01;
    wait_start(lat);
    m_active = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++;
    if ({done, error, m_start, busy, grant_id, m_write} !== 8'h00 || m_address !== '0 || data_rd !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got ctrl %b addr %h data_rd %h expected zeros", {done, error, m_start, busy, grant_id, m_write}, m_address, data_rd);
    end
    m_active = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 2'b00) begin errors++; $display("FAIL rstmid_nodone: got %b expected 00", done); end
    end
    rst_n = 1'b1;
    mdl_last = 1; mdl_rd = '0;
    set_req(0, 32'h30, 4'hF, 1'b1, 32'h3333_3333);
    set_req(1, 32'h40, 4'hF, 1'b1, 32'h4444_4444);
    req_valid = 2'b11;
    wait_start(lat);
    checks++;
    if (lat != 1 || grant_id !== 1'b0 || m_address !== 32'h30) begin
      errors++; $display("FAIL rstmid_tie: got lat %0d gid %b addr %h expected 1 0 00000030", lat, grant_id, m_address);
    end
    run_slave(1, 1, 32'h0, k, d, e);
    req_valid = 2'b10;
    @(negedge clk);
    wait_start(lat);
    run_slave(1, 1, 32'h0, k, d, e);
    req_valid = 2'b00;
    mdl_last = 1;
    checks++;
    if (d !== 2'b10) begin errors++; $display("FAIL rstmid_second: got %b expected 10", d); end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [1:0] pend;
    pend = 2'b00;
    for (int it = 0; it < n; it++) begin
      int id, s, len, lat, k, ek;
      bit eerr;
      logic [1:0] d, e, exp_d;
      logic [DW-1:0] rd;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          set_req(r, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
          pend[r] = 1'b1;
        end
      end
      if (pend == 2'b00) begin
        set_req(0, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
        pend = 2'b01;
      end
      req_valid = pend;
      id = pick(pend);
      mdl_last = id;
      s = $urandom_range(1, 3);
      len = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 8);
      rd = $urandom;
      wait_start(lat);
      checks++;
      if (lat != 1 || grant_id !== 1'(id)) begin
        errors++; $display("FAIL rnd%0d_grant: got lat %0d gid %b expected 1 %0d", it, lat, grant_id, id);
      end
      checks++;
      if (m_address !== pl_addr[id] || m_selection !== pl_sel[id] || m_write !== pl_wr[id] || m_data_wr !== pl_dat[id]) begin
        errors++;
        $display("FAIL rnd%0d_cmd: got %h %h %b %h expected %h %h %b %h", it, m_address, m_selection, m_write, m_data_wr, pl_addr[id], pl_sel[id], pl_wr[id], pl_dat[id]);
      end
      run_slave(s, len, rd, k, d, e);
      xfer_model(s, len, ek, eerr);
      if (!eerr && !pl_wr[id]) mdl_rd = rd;
      exp_d = (id == 1) ? 2'b10 : 2'b01;
      checks++;
      if (k != ek || d !== exp_d || e !== (eerr ? exp_d : 2'b00)) begin
        errors++;
        $display("FAIL rnd%0d_done: got cyc %0d done %b err %b expected %0d %b %b (s=%0d len=%0d)", it, k, d, e, ek, exp_d, eerr ? exp_d : 2'b00, s, len);
      end
      checks++;
      if (data_rd !== mdl_rd || m_data_wr !== pl_dat[id] || m_address !== pl_addr[id]) begin
        errors++;
        $display("FAIL rnd%0d_data: got rd %h wd %h addr %h expected %h %h %h", it, data_rd, m_data_wr, m_address, mdl_rd, pl_dat[id], pl_addr[id]);
      end
      pend[id] = 1'b0;
      req_valid = pend;
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    req_valid = 2'b00;
    m_active  = 1'b0;
    m_data_rd = '0;
    set_req(0, '0, '0, 1'b0, '0);
    set_req(1, '0, '0, 1'b0, '0);
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_timeout();
    test_no_active();
    test_deassert();
    test_reset_mid();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_master_arbiter
